// File: rtl/pellet_renderer.sv
// pellet_renderer: 32x28 map of 2-bit pellet tile codes with a video render port and an eat port.
// Optional power-pellet blink is enabled by defining POWER_BLINK_EN.
module pellet_renderer (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] hpos,
  input  logic [8:0] vpos,
  output logic [1:0] sprite,
  output logic [2:0] yin,
  output logic [2:0] xin,
  input  logic       bm_out,
  output logic       pellet_pixel,
  input  logic       eat_req,
  input  logic [4:0] eat_col,
  input  logic [4:0] eat_row,
  output logic       eat_ack,
  output logic [1:0] eat_kind,
  output logic [9:0] pellets_left,
  output logic       level_clear,
  output logic       ready
);

  localparam logic [9:0] LAST_ADDR = 10'd895;
  localparam logic [4:0] NUM_ROWS  = 5'd28;

  typedef enum logic [1:0] {FILL, IDLE, EAT_RD, EAT_WR} state_t;

  state_t     state;
  logic [1:0] tile_mem [0:895];
  logic [9:0] fill_addr;
  logic [1:0] fill_code_now;
  logic [4:0] eat_col_q;
  logic [4:0] eat_row_q;
  logic       eat_in_map;
  logic [1:0] eat_code_p0;

  logic [9:0] render_addr;
  logic       in_play;
  logic [1:0] code_p0;
  logic [2:0] hpix_p0;
  logic [2:0] vpix_p0;
  logic       vld_p0;
  logic       blank_p0;

  // Columns 0 and 31 are border walls: no lane, horizontal or vertical, reaches them.
  function automatic logic [1:0] fill_code(input logic [4:0] col, input logic [4:0] row);
    logic interior;
    logic corner_col;
    logic corner_row;
    logic lane_h;
    logic lane_v;
    interior   = (col >= 5'd1) && (col <= 5'd30);
    corner_col = (col == 5'd1) || (col == 5'd30);
    corner_row = (row == 5'd1) || (row == 5'd25);
    lane_h     = (row[1:0] == 2'd1);
    lane_v     = ((col % 5'd5) == 5'd1) && (row >= 5'd1) && (row <= 5'd26);
    if (corner_col && corner_row)
      fill_code = 2'd3;
    else if (interior && (lane_h || lane_v))
      fill_code = 2'd1;
    else
      fill_code = 2'd0;
  endfunction

  assign fill_code_now = fill_code(fill_addr[4:0], fill_addr[9:5]);
  assign eat_in_map    = (eat_row_q < NUM_ROWS);
  assign render_addr   = {vpos[7:3], hpos[7:3]};
  assign in_play       = (hpos < 9'd256) && (vpos < 9'd224);

  // Single write port shared by the fill sweep and the eat clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == FILL)
        tile_mem[fill_addr] <= fill_code_now;
      else if ((state == EAT_WR) && eat_in_map)
        tile_mem[{eat_row_q, eat_col_q}] <= 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (state == EAT_RD)
      eat_code_p0 <= eat_in_map ? tile_mem[{eat_row_q, eat_col_q}] : 2'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= FILL;
      fill_addr    <= 10'd0;
      pellets_left <= 10'd0;
      eat_ack      <= 1'b0;
      eat_kind     <= 2'd0;
      ready        <= 1'b0;
      eat_col_q    <= 5'd0;
      eat_row_q    <= 5'd0;
    end else begin
      eat_ack <= 1'b0;
      case (state)
        FILL: begin
          if (fill_code_now != 2'd0)
            pellets_left <= pellets_left + 10'd1;
          if (fill_addr == LAST_ADDR) begin
            fill_addr <= 10'd0;
            state     <= IDLE;
            ready     <= 1'b1;
          end else begin
            fill_addr <= fill_addr + 10'd1;
          end
        end
        IDLE: begin
          if (eat_req) begin
            eat_col_q <= eat_col;
            eat_row_q <= eat_row;
            state     <= EAT_RD;
          end
        end
        EAT_RD: state <= EAT_WR;
        EAT_WR: begin
          eat_ack  <= 1'b1;
          eat_kind <= eat_code_p0;
          if ((eat_code_p0 != 2'd0) && (pellets_left != 10'd0))
            pellets_left <= pellets_left - 10'd1;
          state <= IDLE;
        end
        default: begin
          state <= FILL;
          ready <= 1'b0;
        end
      endcase
    end
  end

  assign level_clear = ready && (pellets_left == 10'd0);

  // Stage p0: tile read; a same-edge eat write is not yet visible here.
  always_ff @(posedge clk) begin
    code_p0 <= tile_mem[render_addr];
    hpix_p0 <= hpos[2:0];
    vpix_p0 <= vpos[2:0];
  end

  always_ff @(posedge clk) begin
    if (reset)
      vld_p0 <= 1'b0;
    else
      vld_p0 <= in_play && (state != FILL);
  end

  assign sprite = vld_p0 ? code_p0 : 2'd0;
  assign yin    = vpix_p0;
  assign xin    = hpix_p0;

`ifdef POWER_BLINK_EN
  logic [4:0] frame_cnt;

  always_ff @(posedge clk) begin
    if (reset)
      frame_cnt <= 5'd0;
    else if ((hpos == 9'd0) && (vpos == 9'd0))
      frame_cnt <= frame_cnt + 5'd1;
  end

  assign blank_p0 = (sprite == 2'd3) && frame_cnt[4];
`else
  assign blank_p0 = 1'b0;
`endif

  // Stage p1: bitmap pixel register.
  always_ff @(posedge clk) begin
    if (reset)
      pellet_pixel <= 1'b0;
    else
      pellet_pixel <= bm_out && !blank_p0;
  end

endmodule

// File: tb/tb_pellet_renderer.sv
// Self-checking bench for pellet_renderer: vector table, hand sequences and a tile-map reference model.
module tb_pellet_renderer;

`ifdef POWER_BLINK_EN
  localparam int BLINK = 1;
`else
  localparam int BLINK = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] hpos;
  logic [8:0] vpos;
  logic [1:0] sprite;
  logic [2:0] yin;
  logic [2:0] xin;
  logic       bm_out;
  logic       pellet_pixel;
  logic       eat_req;
  logic [4:0] eat_col;
  logic [4:0] eat_row;
  logic       eat_ack;
  logic [1:0] eat_kind;
  logic [9:0] pellets_left;
  logic       level_clear;
  logic       ready;

  always #5 clk = ~clk;

  pellet_renderer dut (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos),
    .sprite(sprite), .yin(yin), .xin(xin), .bm_out(bm_out),
    .pellet_pixel(pellet_pixel), .eat_req(eat_req), .eat_col(eat_col),
    .eat_row(eat_row), .eat_ack(eat_ack), .eat_kind(eat_kind),
    .pellets_left(pellets_left), .level_clear(level_clear), .ready(ready)
  );

  // External bitmap ROM: small dot for pellets, filled disc for power pellets.
  function automatic logic bm(input logic [1:0] s, input logic [2:0] y, input logic [2:0] x);
    logic [7:0] r;
    r = 8'h00;
    case (s)
      2'd1: r = ((y == 3'd3) || (y == 3'd4)) ? 8'h18 : 8'h00;
      2'd2: r = 8'hAA;
      2'd3: begin
        case (y)
          3'd0, 3'd7: r = 8'h3C;
          3'd1, 3'd6: r = 8'h7E;
          default:    r = 8'hFF;
        endcase
      end
      default: r = 8'h00;
    endcase
    return r[3'd7 - x];
  endfunction

  assign bm_out = bm(sprite, yin, xin);

  int n_checks = 0;
  int n_pass   = 0;
  int tiles [28][32];
  int pellets_m;
  int fc_m   = 0;
  int fc_prev = 0;

  typedef struct { int h; int v; int code; } vec_t;
  vec_t vecs [16];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual %0d required %0d", name, act, exp);
  endtask

  function automatic int rule_code(input int col, input int row);
    if ((col == 1 || col == 30) && (row == 1 || row == 25)) return 3;
    if (col < 1 || col > 30) return 0;
    if (row % 4 == 1) return 1;
    if ((col % 5 == 1) && row >= 1 && row <= 26) return 1;
    return 0;
  endfunction

  function automatic int prefix_count(input int k);
    int c;
    c = 0;
    for (int a = 0; a < k; a++)
      if (rule_code(a % 32, a / 32) != 0) c++;
    return c;
  endfunction

  task automatic model_reset();
    pellets_m = 0;
    for (int r = 0; r < 28; r++)
      for (int c = 0; c < 32; c++) begin
        tiles[r][c] = rule_code(c, r);
        if (tiles[r][c] != 0) pellets_m++;
      end
  endtask

  function automatic int exp_code(input int h, input int v);
    if (h < 256 && v < 224) return tiles[v / 8][h / 8];
    return 0;
  endfunction

  function automatic int exp_pix(input int code, input int v, input int h);
    int b;
    b = int'(bm(2'(code), 3'(v % 8), 3'(h % 8)));
    if (BLINK != 0 && code == 3 && fc_prev >= 16) b = 0;
    return b;
  endfunction

  task automatic step();
    @(posedge clk);
    fc_prev = fc_m;
    if (reset) fc_m = 0;
    else if (hpos == 9'd0 && vpos == 9'd0) fc_m = (fc_m + 1) % 32;
    #1;
  endtask

  task automatic do_fill();
    int acks;
    acks = 0;
    hpos = 9'd8;
    vpos = 9'd8;
    for (int k = 1; k <= 896; k++) begin
      step();
      if (eat_ack) acks++;
      if (k == 1 || k == 34 || k == 100 || k == 448)
        chk("fill_count", int'(pellets_left), prefix_count(k));
      if (k == 500) chk("fill_sprite_zero", int'(sprite), 0);
      if (k == 895) chk("fill_ready_low", int'(ready), 0);
    end
    chk("fill_ready_high", int'(ready), 1);
    chk("fill_total", int'(pellets_left), 324);
    chk("fill_level_clear", int'(level_clear), 0);
    chk("fill_no_ack", acks, 0);
    model_reset();
  endtask

  task automatic do_eat(input int col, input int row, input string name);
    int prior;
    int lat;
    eat_col = 5'(col);
    eat_row = 5'(row);
    eat_req = 1'b1;
    step();
    eat_req = 1'b0;
    prior = (row < 28) ? tiles[row][col] : 0;
    lat = 0;
    do begin
      step();
      lat++;
    end while (!eat_ack && lat < 6);
    chk({name, "_latency"}, lat, 2);
    if (row < 28) begin
      if (prior != 0 && pellets_m > 0) pellets_m--;
      tiles[row][col] = 0;
    end
    chk({name, "_kind"}, int'(eat_kind), prior);
    chk({name, "_left"}, int'(pellets_left), pellets_m);
    chk({name, "_clear"}, int'(level_clear), (pellets_m == 0) ? 1 : 0);
  endtask

  task automatic stream(input int n, input int rnd, input int h0, input int v0, input string name);
    int ph;
    int pv;
    ph = 0;
    pv = 0;
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        if (rnd != 0) begin
          hpos = 9'($urandom_range(0, 300));
          vpos = 9'($urandom_range(0, 250));
        end else begin
          hpos = 9'(h0 + i % 8);
          vpos = 9'(v0 + i / 8);
        end
      end
      step();
      if (i >= 1) chk(name, int'(pellet_pixel), exp_pix(exp_code(ph, pv), pv, ph));
      ph = int'(hpos);
      pv = int'(vpos);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int order [896];
    int t;
    int j;

    vecs[0]  = '{8, 8, 3};     vecs[1]  = '{0, 0, 0};
    vecs[2]  = '{16, 8, 1};    vecs[3]  = '{8, 16, 1};
    vecs[4]  = '{16, 16, 0};   vecs[5]  = '{256, 8, 0};
    vecs[6]  = '{8, 224, 0};   vecs[7]  = '{248, 8, 0};
    vecs[8]  = '{240, 8, 3};   vecs[9]  = '{8, 200, 3};
    vecs[10] = '{243, 202, 3}; vecs[11] = '{48, 24, 1};
    vecs[12] = '{8, 208, 1};   vecs[13] = '{8, 216, 0};
    vecs[14] = '{255, 223, 0}; vecs[15] = '{100, 43, 1};

    reset = 1'b1;
    hpos = 9'd8;
    vpos = 9'd8;
    eat_req = 1'b0;
    eat_col = 5'd0;
    eat_row = 5'd0;
    step();
    step();
    chk("rst_ready", int'(ready), 0);
    chk("rst_level_clear", int'(level_clear), 0);
    chk("rst_left", int'(pellets_left), 0);
    chk("rst_ack", int'(eat_ack), 0);
    chk("rst_kind", int'(eat_kind), 0);
    chk("rst_sprite", int'(sprite), 0);
    chk("rst_pixel", int'(pellet_pixel), 0);
    reset = 1'b0;
    do_fill();

    for (int i = 0; i < 16; i++) begin
      hpos = 9'(vecs[i].h);
      vpos = 9'(vecs[i].v);
      step();
      chk("vec_sprite", int'(sprite), vecs[i].code);
      chk("vec_yin", int'(yin), vecs[i].v % 8);
      chk("vec_xin", int'(xin), vecs[i].h % 8);
      step();
      chk("vec_pixel", int'(pellet_pixel), exp_pix(vecs[i].code, vecs[i].v, vecs[i].h));
    end

    stream(64, 0, 8, 8, "scan_power");
    stream(64, 0, 0, 0, "scan_empty");
    stream(150, 1, 0, 0, "scan_random");

    // Sixteen frame starts put the blink counter into its dark half, sixteen more wrap it.
    hpos = 9'd0;
    vpos = 9'd0;
    for (int i = 0; i < 16; i++) step();
    stream(64, 0, 240, 8, "blink_power");
    stream(64, 0, 16, 40, "blink_pellet");
    hpos = 9'd0;
    vpos = 9'd0;
    for (int i = 0; i < 16; i++) step();
    stream(64, 0, 240, 8, "wrap_power");

    do_eat(1, 1, "eat_power");
    chk("eat_power_323", int'(pellets_left), 323);
    step();
    chk("ack_pulse_low", int'(eat_ack), 0);
    chk("kind_hold", int'(eat_kind), 3);
    do_eat(1, 1, "eat_again");
    chk("eat_again_323", int'(pellets_left), 323);

    eat_col = 5'd6;
    eat_row = 5'd3;
    eat_req = 1'b1;
    step();
    step();
    step();
    chk("b2b_first_ack", int'(eat_ack), 1);
    chk("b2b_first_kind", int'(eat_kind), 1);
    pellets_m--;
    tiles[3][6] = 0;
    step();
    chk("b2b_gap", int'(eat_ack), 0);
    step();
    step();
    chk("b2b_second_ack", int'(eat_ack), 1);
    chk("b2b_second_kind", int'(eat_kind), 0);
    chk("b2b_left", int'(pellets_left), pellets_m);
    eat_req = 1'b0;
    step();

    hpos = 9'd16;
    vpos = 9'd8;
    eat_col = 5'd2;
    eat_row = 5'd1;
    eat_req = 1'b1;
    step();
    eat_req = 1'b0;
    step();
    step();
    chk("same_tile_ack", int'(eat_ack), 1);
    chk("same_tile_old", int'(sprite), 1);
    pellets_m--;
    tiles[1][2] = 0;
    step();
    chk("same_tile_new", int'(sprite), 0);

    do_eat(3, 30, "eat_row30");
    do_eat(5, 28, "eat_row28");

    for (int i = 0; i < 896; i++) order[i] = i;
    for (int i = 895; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      t = order[i];
      order[i] = order[j];
      order[j] = t;
    end
    for (int i = 0; i < 896; i++) do_eat(order[i] % 32, order[i] / 32, "eat_all");
    chk("all_clear", int'(level_clear), 1);
    chk("all_left", int'(pellets_left), 0);
    do_eat(3, 30, "empty_row30");
    do_eat(30, 25, "empty_again");

    eat_col = 5'd30;
    eat_row = 5'd25;
    eat_req = 1'b1;
    step();
    reset = 1'b1;
    eat_req = 1'b0;
    step();
    chk("abort_ack", int'(eat_ack), 0);
    chk("abort_ready", int'(ready), 0);
    reset = 1'b0;
    eat_col = 5'd1;
    eat_row = 5'd1;
    eat_req = 1'b1;
    do_fill();
    step();
    eat_req = 1'b0;
    chk("pending_wait", int'(eat_ack), 0);
    step();
    step();
    chk("pending_ack", int'(eat_ack), 1);
    chk("pending_kind", int'(eat_kind), 3);
    chk("pending_left", int'(pellets_left), 323);
    tiles[1][1] = 0;
    hpos = 9'd240;
    vpos = 9'd200;
    step();
    chk("refill_restored", int'(sprite), 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
